// File: rtl/pipe_skid_buffer_if.sv
// Valid/ready bus between pipe_skid_buffer and its neighbours.
// Ports:
//   flush               : discard all held entries
//   s_valid/s_ready/s_data : upstream handshake and payload
//   m_valid/m_ready/m_data : downstream handshake and payload
//   occupancy           : number of held entries (0..2)
// modport slave is the buffer's view; modport master is the surrounding logic's view.
interface pipe_skid_buffer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       occupancy;

    modport slave (
        input  flush, s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, occupancy
    );

    modport master (
        output flush, s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, occupancy
    );
endinterface

// File: rtl/pipe_skid_buffer.sv
// Two-entry registered pipeline stage with valid/ready on both sides and
// synchronous flush. All outputs come straight from flops, so no input
// reaches an output combinationally.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : pipe_skid_buffer_if.slave (flush, s_*, m_*, occupancy)
module pipe_skid_buffer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    pipe_skid_buffer_if.slave   bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             m_valid_q;
    logic             s_ready_q;
    logic [1:0]       occupancy_q;

    logic             s_fire;
    logic             m_fire;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;

    assign s_fire = bus.s_valid & s_ready_q;
    assign m_fire = m_valid_q & bus.m_ready;

    // Next-state and register-load decisions; flush overrides any handshake.
    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (s_fire) begin
                        load_main  = 1'b1;
                        state_next = BUSY;
                    end
                end
                BUSY: begin
                    if (s_fire && m_fire) begin
                        load_main = 1'b1;
                    end else if (s_fire) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end else if (m_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // s_ready is low here, so only a drain can happen.
                    if (m_fire) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_next     = BUSY;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // State register plus flags registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            m_valid_q   <= 1'b0;
            s_ready_q   <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state       <= state_next;
            m_valid_q   <= (state_next != EMPTY);
            s_ready_q   <= (state_next != FULL);
            occupancy_q <= (state_next == FULL) ? 2'd2 :
                           (state_next == BUSY) ? 2'd1 : 2'd0;
        end
    end

    // Payload registers; contents are left alone by flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= WIDTH'(0);
            skid_q <= WIDTH'(0);
        end else begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : bus.s_data;
            end
            if (load_skid) begin
                skid_q <= bus.s_data;
            end
        end
    end

    assign bus.m_valid   = m_valid_q;
    assign bus.s_ready   = s_ready_q;
    assign bus.occupancy = occupancy_q;
    assign bus.m_data    = main_q;
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_pipe_skid_buffer;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Reference model: list of held words plus the last head value seen.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] last_out;

    pipe_skid_buffer_if #(.WIDTH(WIDTH)) bus ();

    pipe_skid_buffer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic check_all(input string tag);
        logic [WIDTH-1:0] exp_data;
        exp_data = (q.size() > 0) ? q[0] : last_out;
        chk({tag, ".m_valid"},   WIDTH'(bus.m_valid),   WIDTH'(q.size() > 0));
        chk({tag, ".s_ready"},   WIDTH'(bus.s_ready),   WIDTH'(q.size() < 2));
        chk({tag, ".occupancy"}, WIDTH'(bus.occupancy), WIDTH'(q.size()));
        chk({tag, ".m_data"},    bus.m_data,            exp_data);
    endtask

    // One clock: drive inputs, advance the model at the edge, then check.
    task automatic cycle(input logic rst, input logic fl, input logic sv,
                         input logic [WIDTH-1:0] sd, input logic mr, input string tag);
        bit sf;
        bit mf;
        reset       = rst;
        bus.flush   = fl;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        sf = sv && (q.size() < 2);
        mf = mr && (q.size() > 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            last_out = '0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (mf) void'(q.pop_front());
            if (sf) q.push_back(sd);
        end
        if (q.size() > 0) last_out = q[0];
        #1;
        check_all(tag);
    endtask

    initial begin
        logic             sv;
        logic [WIDTH-1:0] sd;
        logic             pending;
        checks   = 0;
        errors   = 0;
        last_out = '0;
        reset    = 1'b1;
        bus.flush   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        #1;

        // Reset with an offer pending: nothing accepted.
        cycle(1, 0, 1, 32'hDEAD, 0, "reset0");
        cycle(1, 0, 1, 32'hDEAD, 0, "reset1");
        chk("reset.m_data_zero", bus.m_data, 32'h0);
        chk("reset.occ_zero", WIDTH'(bus.occupancy), 32'h0);

        // Streaming with m_ready held high.
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 0, 1, WIDTH'(i), 1, "stream");
            chk("stream.word", bus.m_data, WIDTH'(i));
            chk("stream.occ", WIDTH'(bus.occupancy), 32'h1);
        end
        cycle(0, 0, 0, '0, 1, "stream_drain");
        chk("stream_drain.m_valid", WIDTH'(bus.m_valid), 32'h0);

        // Back-pressure: A and B accepted, C held upstream.
        cycle(0, 0, 1, 32'hA, 0, "bp_a");
        cycle(0, 0, 1, 32'hB, 0, "bp_b");
        cycle(0, 0, 1, 32'hC, 0, "bp_c0");
        cycle(0, 0, 1, 32'hC, 0, "bp_c1");
        chk("bp.s_ready_low", WIDTH'(bus.s_ready), 32'h0);
        chk("bp.occ_two", WIDTH'(bus.occupancy), 32'h2);
        chk("bp.head_stable", bus.m_data, 32'hA);
        cycle(0, 0, 1, 32'hC, 1, "bp_rel0");
        chk("bp.order_b", bus.m_data, 32'hB);
        cycle(0, 0, 1, 32'hC, 1, "bp_rel1");
        chk("bp.order_c", bus.m_data, 32'hC);
        cycle(0, 0, 0, '0, 1, "bp_rel2");

        // Simultaneous fire in BUSY.
        cycle(0, 0, 1, 32'h5, 0, "sim_load");
        cycle(0, 0, 1, 32'h6, 1, "sim_both");
        chk("sim.m_data", bus.m_data, 32'h6);
        chk("sim.occ", WIDTH'(bus.occupancy), 32'h1);
        cycle(0, 0, 0, '0, 1, "sim_drain");

        // Flush in FULL with concurrent handshakes.
        cycle(0, 0, 1, 32'h11, 0, "fl_a");
        cycle(0, 0, 1, 32'h22, 0, "fl_b");
        cycle(0, 1, 1, 32'h33, 1, "fl_do");
        chk("flush.m_valid", WIDTH'(bus.m_valid), 32'h0);
        chk("flush.s_ready", WIDTH'(bus.s_ready), 32'h1);
        cycle(0, 1, 1, 32'h44, 1, "fl_hold");
        cycle(0, 0, 0, '0, 1, "fl_after");
        chk("flush.nothing_left", WIDTH'(bus.m_valid), 32'h0);

        // Reset in FULL, then a fresh push.
        cycle(0, 0, 1, 32'h1, 0, "rst_a");
        cycle(0, 0, 1, 32'h2, 0, "rst_b");
        cycle(1, 0, 0, '0, 0, "rst_do");
        chk("rst_mid.m_data", bus.m_data, 32'h0);
        cycle(0, 0, 1, 32'h7, 0, "rst_push");
        chk("rst_mid.push7", bus.m_data, 32'h7);
        cycle(0, 0, 0, '0, 1, "rst_drain");

        // Random traffic; upstream holds its offer until accepted.
        pending = 1'b0;
        sv = 1'b0;
        sd = '0;
        for (int n = 0; n < 600; n++) begin
            bit rst_r;
            bit fl_r;
            bit mr_r;
            if (!pending) begin
                sv = 1'($urandom_range(0, 1));
                sd = WIDTH'($urandom);
            end
            rst_r = ($urandom_range(0, 63) == 0);
            fl_r  = ($urandom_range(0, 31) == 0);
            mr_r  = 1'($urandom_range(0, 2) != 0);
            pending = sv && !(q.size() < 2) && !rst_r && !fl_r;
            cycle(rst_r, fl_r, sv, sd, mr_r, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_skid_buffer.md
# pipe_skid_buffer

Two-entry registered pipeline stage with a valid/ready handshake on both sides and synchronous flush. It is the back-pressure-aware counterpart to the plain enable flip-flop used between pipeline stages. The enable flop holds a value when told to. This block decides, from downstream readiness, when to accept, hold, or hand off a word, and it drives ready back upstream. It sits between pipeline stages and in front of multi-cycle units such as a divider or memory port. Every output is registered, so there is no combinational path from any input to any output.

## Interface
- WIDTH, 32, payload width in bits
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clock clk
- flush  in  1  synchronous discard of all held entries
- s_valid  in  1  upstream offers s_data
- s_ready  out  1  block can accept a word this cycle
- s_data  in  WIDTH  upstream payload
- m_valid  out  1  m_data holds a valid word
- m_ready  in  1  downstream accepts m_data this cycle
- m_data  out  WIDTH  downstream payload
- occupancy  out  2  number of held entries, 0..2

## Operation
- Storage is a main register (drives m_data) and a skid register.
- Handshake events: s_fire = s_valid & s_ready; m_fire = m_valid & m_ready.
- States:
  - EMPTY: 0 entries.
  - BUSY: main register valid.
  - FULL: main and skid registers both valid.
- Outputs are decoded from registered state only:
  - m_valid = (state != EMPTY)
  - s_ready = (state != FULL)
  - occupancy = 0, 1 or 2 for EMPTY, BUSY, FULL.
- Transitions when not in reset or flush:
  - EMPTY, s_fire: main <= s_data, go to BUSY.
  - BUSY, s_fire & m_fire: main <= s_data, stay in BUSY.
  - BUSY, s_fire only: skid <= s_data, go to FULL.
  - BUSY, m_fire only: go to EMPTY.
  - FULL, m_fire: main <= skid, go to BUSY. s_fire cannot occur in FULL.
  - Any other case: hold.
- Priority: reset > flush > normal transitions.
- reset: go to EMPTY; main and skid cleared to 0.
- flush: go to EMPTY. Data registers keep their values and have no meaning. s_fire and m_fire in the flush cycle are discarded, so no word is accepted or delivered.
- Ordering: words leave in the order they were accepted. None is dropped or duplicated except by flush or reset.
- Stability: while m_valid=1 and m_ready=0, m_data and m_valid stay constant until m_fire, flush or reset.
- Upstream must hold s_valid and s_data stable until s_fire; the block does not check this.

## Timing
- Reset values: m_valid=0, s_ready=1, occupancy=0, m_data=0.
- Latency: s_fire in cycle N gives m_valid=1 and m_data=word in cycle N+1, when the block was EMPTY or BUSY with m_fire.
- Throughput: one word per cycle, with no bubbles, while m_ready is held at 1.
- Back-pressure: s_ready falls in the cycle after the second word is accepted without a drain. It rises again in the cycle after the m_fire that leaves FULL.
- Simultaneous s_fire and m_fire in BUSY: occupancy stays at 1 and m_data updates to the new word next cycle.
- Flush or reset in any state: m_valid=0, s_ready=1 and occupancy=0 in the next cycle.
- Flush held for several cycles: the block stays in EMPTY with s_ready=1 and accepts nothing.

## Test plan
- Reset:
  - Stimulus: assert reset for 2 cycles with s_valid=1 and s_data=0xDEAD.
  - Required: m_valid=0, s_ready=1, occupancy=0, m_data=0, and nothing is accepted.
- Streaming:
  - Stimulus: m_ready=1; send 0x1, 0x2, 0x3, 0x4 on consecutive cycles.
  - Required: m_data shows 0x1..0x4 on consecutive cycles, each one cycle after its s_fire, with no bubbles and occupancy=1 throughout.
- Back-pressure:
  - Stimulus: m_ready=0; offer 0xA, 0xB, 0xC.
  - Required: 0xA and 0xB are accepted, then s_ready=0 and occupancy=2, with 0xC held upstream. m_data=0xA stays stable.
  - Stimulus: raise m_ready.
  - Required: output order is 0xA, 0xB, 0xC.
- Simultaneous events:
  - Stimulus: in BUSY holding 0x5, s_fire with 0x6 and m_fire in the same cycle.
  - Required: next cycle m_data=0x6 and occupancy=1.
- Flush in FULL:
  - Stimulus: fill with 0x11 and 0x22, then assert flush together with s_valid and m_ready.
  - Required: next cycle m_valid=0, s_ready=1, occupancy=0. Neither 0x11 nor 0x22 is ever delivered, and the flush-cycle input is dropped.
- Reset mid-operation:
  - Stimulus: assert reset in FULL.
  - Required: next cycle matches reset values.
  - Stimulus: then push 0x7.
  - Required: 0x7 appears on m_data one cycle later.
